instr_stream_driver: RTL

Host-side partner of the processor tile's 12-bit pin interface. Buffers instruction words from an upstream valid/ready producer in a small FIFO. Issues each word onto the tile's 12-bit input bus and waits a fixed pipeline latency. Samples the tile's 12-bit result bus and hands the result downstream over valid/ready. Sits in the bring-up/test harness between the stimulus source and the chip pins.

---
 rtl/instr_stream_driver.sv | 97 +++++++++
 1 files changed

// File: rtl/instr_stream_driver.sv
// instr_stream_driver: buffers instruction words, issues them one at a time to a fixed-latency tile and returns results over valid/ready.
// Optional macro ISD_STATS_EN adds saturating issued_cnt/retired_cnt outputs.
module instr_stream_driver #(
  parameter int WIDTH   = 12,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] chip_instr,
  input  logic [WIDTH-1:0] chip_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef ISD_STATS_EN
  ,
  output logic [15:0]      issued_cnt,
  output logic [15:0]      retired_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, HOLD} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [3:0] cnt;
  logic empty, full, push, pop, hs;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // in_ready is held low while reset is asserted so every output reads 0 during reset
  assign in_ready = reset && !full;
  assign push = in_valid && in_ready;
  assign busy = (state != IDLE) || !empty;
  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    hs = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_nxt = empty ? IDLE : ISSUE;
      end
      ISSUE: state_nxt = (LATENCY == 1) ? CAPTURE : WAIT;
      WAIT: state_nxt = (cnt == 4'd1) ? CAPTURE : WAIT;
      CAPTURE: state_nxt = HOLD;
      HOLD: begin
        hs = out_ready;
        pop = out_ready && !empty;
        state_nxt = !out_ready ? HOLD : (empty ? IDLE : ISSUE);
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= in_data;
  end
  // WAIT leaves on the cycle its last decrement reaches zero, giving CAPTURE exactly LATENCY cycles after ISSUE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      chip_instr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        chip_instr <= mem[rptr[AW-1:0]];
      end
      if (state == ISSUE) cnt <= 4'(LATENCY - 1);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (state == CAPTURE) begin
        out_data <= chip_result;
        out_valid <= 1'b1;
      end else if (hs) out_valid <= 1'b0;
    end
  end
`ifdef ISD_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issued_cnt <= '0;
      retired_cnt <= '0;
    end else begin
      if (pop && issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 1'b1;
      if (hs && retired_cnt != 16'hFFFF) retired_cnt <= retired_cnt + 1'b1;
    end
  end
`endif
endmodule
